// File: rtl/tpu_pkg.sv
// tpu_pkg: shared TPU datapath defaults, collector FSM states and row-counter width helper
package tpu_pkg;
  localparam int DATAWITH = 16;
  localparam int ARRAY_SIZE = 2;
  typedef enum logic [0:0] {COLLECT = 1'b0, HOLD = 1'b1} state_e;
  function automatic int row_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/result_collector_if.sv
// result_collector_if: column result streams in, assembled tile and valid/ack handshake out
interface result_collector_if import tpu_pkg::*; #(
  parameter int datawith = DATAWITH,
  parameter int array_size = ARRAY_SIZE
) ();
  logic clr;
  logic [array_size-1:0] col_valid;
  logic [array_size*datawith-1:0] col_data;
  logic result_ack;
  logic [array_size*array_size*datawith-1:0] result;
  logic result_valid;
  logic overflow;
  logic [7:0] tile_cnt;
  modport master (
    output clr, col_valid, col_data, result_ack,
    input  result, result_valid, overflow, tile_cnt
  );
  modport slave (
    input  clr, col_valid, col_data, result_ack,
    output result, result_valid, overflow, tile_cnt
  );
endinterface

// File: rtl/result_collector_col_capture.sv
// col_capture: one column's row counter and element registers; optional ReLU via RESULT_COLLECTOR_RELU_EN
module col_capture import tpu_pkg::*; #(
  parameter int datawith = DATAWITH,
  parameter int array_size = ARRAY_SIZE
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic ack_i,
  input  logic valid_i,
  input  logic [datawith-1:0] data_i,
  output logic [array_size*datawith-1:0] elems_o,
  output logic full_o,
  output logic drop_o
);
  localparam int cw = row_cnt_w(array_size);
  localparam logic [cw-1:0] last = cw'(array_size);
  logic [cw-1:0] cnt_q, cnt_d;
  logic [array_size-1:0][datawith-1:0] elem_q;
  logic [datawith-1:0] val;
  logic cap;
`ifdef RESULT_COLLECTOR_RELU_EN
  assign val = data_i[datawith-1] ? '0 : data_i;
`else
  assign val = data_i;
`endif
  assign cap = valid_i & ~clr_i & ~ack_i & (cnt_q != last);
  assign drop_o = valid_i & ~clr_i & (cnt_q == last);
  assign elems_o = elem_q;
  assign full_o = cnt_d == last;
  // next row count: a tile abort or accepted ack restarts the column
  always_comb cnt_d = (clr_i | ack_i) ? '0 : cnt_q + cw'(cap);
  // store the element at the current row and advance
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      elem_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      for (int r = 0; r < array_size; r++)
        if (cap && cnt_q == cw'(r)) elem_q[r] <= val;
    end
  end
endmodule

// File: rtl/result_collector.sv
// result_collector: assembles skewed column results into one tile and holds it until acked (RESULT_COLLECTOR_RELU_EN enables ReLU)
module result_collector import tpu_pkg::*; #(
  parameter int datawith = DATAWITH,
  parameter int array_size = ARRAY_SIZE
) (
  input logic clk,
  input logic rst,
  result_collector_if.slave bus
);
  logic [array_size-1:0] full, drop;
  logic [array_size-1:0][array_size*datawith-1:0] elems;
  state_e state_q, state_d;
  logic [7:0] tile_cnt_q, tile_cnt_d;
  logic overflow_q, overflow_d;
  logic ack;
  assign ack = (state_q == HOLD) & bus.result_ack;
  genvar c, r;
  generate
    for (c = 0; c < array_size; c++) begin : g_col
      col_capture #(.datawith(datawith), .array_size(array_size)) u_col (
        .clk(clk), .rst(rst), .clr_i(bus.clr), .ack_i(ack),
        .valid_i(bus.col_valid[c]), .data_i(bus.col_data[c*datawith +: datawith]),
        .elems_o(elems[c]), .full_o(full[c]), .drop_o(drop[c])
      );
      for (r = 0; r < array_size; r++) begin : g_row
        assign bus.result[(r*array_size + c)*datawith +: datawith] = elems[c][r*datawith +: datawith];
      end
    end
  endgenerate
  // tile state, ack counting and sticky drop flag
  always_comb begin
    state_d = (bus.clr | ack) ? COLLECT : (state_q == COLLECT && &full) ? HOLD : state_q;
    tile_cnt_d = tile_cnt_q + 8'(ack & ~bus.clr);
    overflow_d = overflow_q | (|drop);
  end
  // register control state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      tile_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tile_cnt_q <= tile_cnt_d;
      overflow_q <= overflow_d;
    end
  end
  assign bus.result_valid = state_q == HOLD;
  assign bus.tile_cnt = tile_cnt_q;
  assign bus.overflow = overflow_q;
endmodule
